// File: rtl/msi_wb_mux.sv
// msi_wb_mux: single-master, NUM_SLAVES-slave Wishbone B3 address decoder/mux.
//
// Routes the master cycle to the lowest-indexed slave whose window matches.
// The match rule is ((adr ^ base) & mask) == 0. Terminations and read data
// come back combinationally from that slave.
//
// Build option:
//   MSI_WB_MUX_UNMAPPED_ERR_EN - when defined, an access that hits no window
//   gets a registered one-cycle err pulse. Otherwise no termination is given.
//
// Ports:
//   wb_clk_i, wb_rst_i         clock, async active-low reset
//   wbm_*_i / wbm_*_o          master side (adr, dat, sel, we, cyc, stb, cti, bte /
//                              dat, ack, err, rty)
//   wbs_*_o / wbs_*_i          per-slave copies of the master request /
//                              per-slave read data and terminations
module msi_wb_mux #(
  parameter int                       NUM_SLAVES = 2,
  parameter int                       AW         = 32,
  parameter int                       DW         = 32,
  parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR = '0,
  parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK = '0
) (
  input  logic                                wb_clk_i,
  input  logic                                wb_rst_i,
  input  logic [AW-1:0]                       wbm_adr_i,
  input  logic [DW-1:0]                       wbm_dat_i,
  input  logic [DW/8-1:0]                     wbm_sel_i,
  input  logic                                wbm_we_i,
  input  logic                                wbm_cyc_i,
  input  logic                                wbm_stb_i,
  input  logic [2:0]                          wbm_cti_i,
  input  logic [1:0]                          wbm_bte_i,
  output logic [DW-1:0]                       wbm_dat_o,
  output logic                                wbm_ack_o,
  output logic                                wbm_err_o,
  output logic                                wbm_rty_o,
  output logic [NUM_SLAVES-1:0][AW-1:0]       wbs_adr_o,
  output logic [NUM_SLAVES-1:0][DW-1:0]       wbs_dat_o,
  output logic [NUM_SLAVES-1:0][DW/8-1:0]     wbs_sel_o,
  output logic [NUM_SLAVES-1:0]               wbs_we_o,
  output logic [NUM_SLAVES-1:0]               wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]               wbs_stb_o,
  output logic [NUM_SLAVES-1:0][2:0]          wbs_cti_o,
  output logic [NUM_SLAVES-1:0][1:0]          wbs_bte_o,
  input  logic [NUM_SLAVES-1:0][DW-1:0]       wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]               wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]               wbs_err_i,
  input  logic [NUM_SLAVES-1:0]               wbs_rty_i
);

  logic [NUM_SLAVES-1:0] match;
  logic [NUM_SLAVES-1:0] sel_oh;
  logic                  any_match;
  logic                  slv_err;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      match[i] = ((wbm_adr_i ^ MATCH_ADDR[i*AW +: AW]) & MATCH_MASK[i*AW +: AW]) == '0;
    end
  end

  // Walk from the top down so the lowest matching index is the last writer.
  always_comb begin
    sel_oh = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
    any_match = |match;
  end

  always_comb begin
    for (int i = 0; i < NUM_SLAVES; i++) begin
      wbs_adr_o[i] = wbm_adr_i;
      wbs_dat_o[i] = wbm_dat_i;
      wbs_sel_o[i] = wbm_sel_i;
      wbs_we_o[i]  = wbm_we_i;
      wbs_stb_o[i] = wbm_stb_i;
      wbs_cti_o[i] = wbm_cti_i;
      wbs_bte_o[i] = wbm_bte_i;
      wbs_cyc_o[i] = wbm_cyc_i & sel_oh[i];
    end
  end

  // sel_oh is all-zero when nothing matches, so the return path reads as 0.
  always_comb begin
    wbm_dat_o = '0;
    wbm_ack_o = 1'b0;
    wbm_rty_o = 1'b0;
    slv_err   = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      wbm_dat_o = wbm_dat_o | (wbs_dat_i[i] & {DW{sel_oh[i]}});
      wbm_ack_o = wbm_ack_o | (wbs_ack_i[i] & sel_oh[i]);
      wbm_rty_o = wbm_rty_o | (wbs_rty_i[i] & sel_oh[i]);
      slv_err   = slv_err   | (wbs_err_i[i] & sel_oh[i]);
    end
  end

`ifdef MSI_WB_MUX_UNMAPPED_ERR_EN
  logic err_q;
  logic err_d;

  // Self-clearing: a held unmapped strobe yields a pulse every other cycle.
  always_comb begin
    err_d = wbm_cyc_i & wbm_stb_i & ~any_match & ~err_q;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign wbm_err_o = slv_err | err_q;
`else
  // Without the error generator the block is purely combinational.
  logic unused_clk_rst;
  assign unused_clk_rst = wb_clk_i ^ wb_rst_i ^ any_match;
  assign wbm_err_o      = slv_err;
`endif

endmodule

// File: tb/tb_msi_wb_mux.sv
// Testbench for msi_wb_mux: directed routing, unmapped-error and reset cases,
// a priority check on a second instance with overlapping windows, then
// randomized routing and memory traffic checked against a reference model.
module tb_msi_wb_mux;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [NS*AW-1:0] MA  = {32'h300, 32'h200, 32'h100, 32'h000};
  localparam logic [NS*AW-1:0] MAO = {32'h300, 32'h200, 32'h000, 32'h000};
  localparam logic [NS*AW-1:0] MM  = {4{32'hffff_ff00}};
`ifdef MSI_WB_MUX_UNMAPPED_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] adr;
  logic [DW-1:0] dat;
  logic [3:0]    sel;
  logic          we, cyc, stb;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic [DW-1:0] m_dat;
  logic          m_ack, m_err, m_rty;

  logic [NS-1:0][AW-1:0] s_adr;
  logic [NS-1:0][DW-1:0] s_dat;
  logic [NS-1:0][3:0]    s_sel;
  logic [NS-1:0]         s_we, s_cyc, s_stb;
  logic [NS-1:0][2:0]    s_cti;
  logic [NS-1:0][1:0]    s_bte;
  logic [NS-1:0][DW-1:0] s_dat_i;
  logic [NS-1:0]         s_ack_i, s_err_i, s_rty_i;

  logic [NS-1:0][AW-1:0] o_adr;
  logic [NS-1:0][DW-1:0] o_dat;
  logic [NS-1:0][3:0]    o_sel;
  logic [NS-1:0]         o_we, o_cyc, o_stb;
  logic [NS-1:0][2:0]    o_cti;
  logic [NS-1:0][1:0]    o_bte;
  logic [NS-1:0][DW-1:0] o_dat_i;
  logic [NS-1:0]         o_ack_i, o_err_i, o_rty_i;
  logic [DW-1:0]         o_m_dat;
  logic                  o_m_ack, o_m_err, o_m_rty;

  // Slave behaviour: forced values, or auto mode with small memories that ack at once.
  logic                  auto_mode;
  logic [NS-1:0][DW-1:0] f_dat;
  logic [NS-1:0]         f_ack, f_err, f_rty;
  logic [31:0]           smem [NS][64];
  int                    wcnt [NS] = '{default: 0};

  msi_wb_mux #(.NUM_SLAVES(NS), .AW(AW), .DW(DW), .MATCH_ADDR(MA), .MATCH_MASK(MM)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .wbm_adr_i(adr), .wbm_dat_i(dat), .wbm_sel_i(sel), .wbm_we_i(we),
    .wbm_cyc_i(cyc), .wbm_stb_i(stb), .wbm_cti_i(cti), .wbm_bte_i(bte),
    .wbm_dat_o(m_dat), .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty),
    .wbs_adr_o(s_adr), .wbs_dat_o(s_dat), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
    .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
    .wbs_dat_i(s_dat_i), .wbs_ack_i(s_ack_i), .wbs_err_i(s_err_i), .wbs_rty_i(s_rty_i)
  );

  msi_wb_mux #(.NUM_SLAVES(NS), .AW(AW), .DW(DW), .MATCH_ADDR(MAO), .MATCH_MASK(MM)) u_ovl (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .wbm_adr_i(adr), .wbm_dat_i(dat), .wbm_sel_i(sel), .wbm_we_i(we),
    .wbm_cyc_i(cyc), .wbm_stb_i(stb), .wbm_cti_i(cti), .wbm_bte_i(bte),
    .wbm_dat_o(o_m_dat), .wbm_ack_o(o_m_ack), .wbm_err_o(o_m_err), .wbm_rty_o(o_m_rty),
    .wbs_adr_o(o_adr), .wbs_dat_o(o_dat), .wbs_sel_o(o_sel), .wbs_we_o(o_we),
    .wbs_cyc_o(o_cyc), .wbs_stb_o(o_stb), .wbs_cti_o(o_cti), .wbs_bte_o(o_bte),
    .wbs_dat_i(o_dat_i), .wbs_ack_i(o_ack_i), .wbs_err_i(o_err_i), .wbs_rty_i(o_rty_i)
  );

  always_comb begin
    s_dat_i = '0;
    s_ack_i = '0;
    s_err_i = '0;
    s_rty_i = '0;
    o_dat_i = '0;
    for (int i = 0; i < NS; i++) begin
      s_dat_i[i] = auto_mode ? smem[i][s_adr[i][7:2]] : f_dat[i];
      s_ack_i[i] = auto_mode ? (s_cyc[i] & s_stb[i]) : f_ack[i];
      s_err_i[i] = auto_mode ? 1'b0 : f_err[i];
      s_rty_i[i] = auto_mode ? 1'b0 : f_rty[i];
      o_dat_i[i] = 32'(32'h0000_00A0 + i);
    end
  end
  assign o_ack_i = o_cyc & o_stb;
  assign o_err_i = '0;
  assign o_rty_i = '0;

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (auto_mode && s_cyc[i] && s_stb[i] && s_we[i]) begin
        smem[i][s_adr[i][7:2]] <= s_dat[i];
        wcnt[i] <= wcnt[i] + 1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic        exp_errq;
  logic [31:0] ref_mem [int];
  int          wr_q [$];
  int          exp_wcnt [NS];
  int          total_wr;

  initial begin
    adr = '0; dat = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0; cti = '0; bte = '0;
    auto_mode = 1'b0; f_dat = '0; f_ack = '0; f_err = '0; f_rty = '0;
    exp_errq = 1'b0; total_wr = 0;
    for (int i = 0; i < NS; i++) exp_wcnt[i] = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_err", m_err, 1'b0);
    check("rst_cyc", s_cyc, 4'b0000);
    rst_n = 1'b1;

    // Write 0xDEADBEEF to 0x104
    @(negedge clk);
    adr = 32'h104; dat = 32'hDEAD_BEEF; we = 1'b1; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    cti = 3'b010; bte = 2'b01; f_ack = 4'b0010;
    #4;
    check("wr_cyc", s_cyc, 4'b0010);
    check("wr_ack", m_ack, 1'b1);
    check("wr_dat_bcast", s_dat[1], 32'hDEAD_BEEF);
    check("wr_adr_bcast", s_adr[3], 32'h104);
    check("wr_sel_bcast", s_sel[2], 4'hF);
    check("wr_cti_bcast", s_cti[0], 3'b010);

    // Read 0x2FC from slave 2
    @(negedge clk);
    adr = 32'h2FC; we = 1'b0; cti = 3'b000; bte = 2'b00;
    f_dat[0] = 32'h1111_1111; f_dat[1] = 32'h2222_2222; f_dat[2] = 32'h1234_5678; f_dat[3] = 32'h4444_4444;
    f_ack = 4'b0100;
    #4;
    check("rd_cyc", s_cyc, 4'b0100);
    check("rd_dat", m_dat, 32'h1234_5678);
    check("rd_ack", m_ack, 1'b1);

    // Unmapped access held for several cycles; pulse re-arms every other cycle
    @(negedge clk);
    adr = 32'h400; f_ack = '0;
    #4;
    check("unm_cyc", s_cyc, 4'b0000);
    check("unm_dat", m_dat, 32'h0);
    check("unm_err_a", m_err, 1'b0);
    @(negedge clk); #4;
    check("unm_err_b", m_err, ERR_EN);
    @(negedge clk); #4;
    check("unm_err_c", m_err, 1'b0);
    @(negedge clk); #4;
    check("unm_err_d", m_err, ERR_EN);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    #4;
    check("unm_err_e", m_err, 1'b0);

    // Reset asserted during an unmapped access
    @(negedge clk);
    adr = 32'h400; cyc = 1'b1; stb = 1'b1;
    @(negedge clk); #2;
    check("rst_mid_pre", m_err, ERR_EN);
    rst_n = 1'b0;
    #1;
    check("rst_mid_err", m_err, 1'b0);
    adr = 32'h104; f_ack = 4'b0010;
    #1;
    check("rst_route", m_ack, 1'b1);
    @(negedge clk);
    rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; f_ack = '0;

    // Overlapping windows resolve to the lower index
    @(negedge clk);
    adr = 32'h010; cyc = 1'b1; stb = 1'b1;
    #4;
    check("ovl_cyc", o_cyc, 4'b0001);
    check("ovl_dat", o_m_dat, 32'hA0);
    check("ovl_main", s_cyc, 4'b0001);
    @(negedge clk);
    adr = 32'h210;
    #4;
    check("ovl_cyc2", o_cyc, 4'b0100);
    check("ovl_dat2", o_m_dat, 32'hA2);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    exp_errq = 1'b0;

    // Randomized routing with random slave responses
    for (int n = 0; n < 200; n++) begin
      int          idx;
      bit          hit;
      logic [3:0]  e_cyc;
      @(negedge clk);
      adr = 32'($urandom_range(0, 32'h7FF)) & 32'hFFFF_FFFC;
      cyc = 1'($urandom); stb = 1'($urandom); we = 1'($urandom);
      dat = $urandom; cti = 3'($urandom); bte = 2'($urandom); sel = 4'($urandom);
      for (int i = 0; i < NS; i++) f_dat[i] = $urandom;
      f_ack = 4'($urandom); f_err = 4'($urandom); f_rty = 4'($urandom);
      #4;
      hit   = adr < 32'h400;
      idx   = int'(adr >> 8) % NS;
      e_cyc = (cyc && hit) ? 4'(1 << idx) : 4'b0000;
      check("rnd_cyc", s_cyc, e_cyc);
      check("rnd_dat", m_dat, hit ? f_dat[idx] : 32'h0);
      check("rnd_ack", m_ack, hit ? f_ack[idx] : 1'b0);
      check("rnd_rty", m_rty, hit ? f_rty[idx] : 1'b0);
      check("rnd_err", m_err, (hit ? f_err[idx] : 1'b0) | exp_errq);
      check("rnd_cti", s_cti[idx], cti);
      exp_errq = ERR_EN && cyc && stb && !hit && !exp_errq;
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; f_ack = '0; f_err = '0; f_rty = '0;
    @(negedge clk);

    // Memory traffic: 1000 single-beat accesses over 0x000-0x3FF
    auto_mode = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      int a;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; sel = 4'hF; cti = 3'b000; bte = 2'b00;
      if (wr_q.size() != 0 && $urandom_range(0, 1) == 1) begin
        a   = wr_q[$urandom_range(0, wr_q.size() - 1)];
        adr = 32'(a); we = 1'b0;
        #4;
        check("trf_rd_ack", m_ack, 1'b1);
        check("trf_rd_dat", m_dat, ref_mem[a]);
      end else begin
        a   = int'($urandom_range(0, 255)) * 4;
        adr = 32'(a); we = 1'b1; dat = $urandom;
        if (!ref_mem.exists(a)) wr_q.push_back(a);
        ref_mem[a] = dat;
        exp_wcnt[a / 256]++;
        total_wr++;
        #4;
        check("trf_wr_ack", m_ack, 1'b1);
      end
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    begin
      int sum;
      sum = 0;
      for (int i = 0; i < NS; i++) begin
        check("trf_wcnt", 64'(wcnt[i]), 64'(exp_wcnt[i]));
        sum += wcnt[i];
      end
      check("trf_wsum", 64'(sum), 64'(total_wr));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/msi_wb_mux.md
# msi_wb_mux

Single-master, N-slave Wishbone B3 address decoder/multiplexer for the MSI bus fabric. It routes one master's cycle to the slave whose address window matches, and returns that slave's data and handshake to the master. An access that matches no window is terminated with an internally generated bus error. It sits between a CPU/BFM master port and a set of peripheral or memory slaves.

## Interface
- NUM_SLAVES, 2, number of slave ports (≥1)
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- MATCH_ADDR, 0, NUM_SLAVES*AW bits; slice i is the base address of slave i
- MATCH_MASK, 0, NUM_SLAVES*AW bits; slice i is the compare mask of slave i
- wb_clk_i  in  1  clock; all state on rising edge
- wb_rst_i  in  1  reset, asynchronous, active-low
- wbm_adr_i/wbm_dat_i/wbm_sel_i  in  AW/DW/DW/8  master address, write data, byte selects
- wbm_we_i/wbm_cyc_i/wbm_stb_i  in  1 each  master write enable, cycle, strobe
- wbm_cti_i/wbm_bte_i  in  3/2  burst cycle type, burst type
- wbm_dat_o  out  DW  read data to master
- wbm_ack_o/wbm_err_o/wbm_rty_o  out  1 each  termination to master
- wbs_adr_o/wbs_dat_o/wbs_sel_o  out  [NUM_SLAVES][AW]/[NUM_SLAVES][DW]/[NUM_SLAVES][DW/8]  per-slave copies
- wbs_we_o/wbs_cyc_o/wbs_stb_o  out  NUM_SLAVES each  per-slave controls
- wbs_cti_o/wbs_bte_o  out  [NUM_SLAVES][3]/[NUM_SLAVES][2]  per-slave burst info
- wbs_dat_i  in  [NUM_SLAVES][DW]  slave read data
- wbs_ack_i/wbs_err_i/wbs_rty_i  in  NUM_SLAVES each  slave terminations

## Operation
- Match vector: match[i] = ((wbm_adr_i ^ MATCH_ADDR[i]) & MATCH_MASK[i]) == 0.
- Selected slave: the lowest index i with match[i] set. Overlapping windows resolve to the lower index. The select index has width clog2(NUM_SLAVES), minimum 1.
- Broadcast to all slaves, unmodified: adr, dat, sel, we, stb, cti, bte.
- wbs_cyc_o[i] = wbm_cyc_i & (i == selected) & any_match. Only one slave's cyc can be high at a time.
- wbm_dat_o, wbm_ack_o and wbm_rty_o come from the selected slave. When no window matches, wbm_dat_o = 0 and ack = rty = 0.
- wbm_err_o = wbs_err_i[selected] | err_q.
- err_q is a register. Its next value is wbm_cyc_i & wbm_stb_i & ~any_match & ~err_q. The result is a one-cycle error pulse per unmapped access.
- Address bits are not translated. Slaves receive the full master address.

## Timing
- Master-to-slave and slave-to-master paths are purely combinational with zero added latency. Slave ack/err/rty reach the master in the same cycle.
- Unmapped access: wbm_err_o asserts one clock after cyc&stb is first sampled and lasts exactly one cycle. It re-arms if the master keeps cyc&stb high.
- Reset: err_q clears to 0 asynchronously on wb_rst_i low. All outputs are then combinational functions of the inputs, so wbm_err_o = 0 while idle.
- Reset mid-access: err_q clears immediately. Combinational routing continues regardless of reset.
- The address must be held stable while cyc is high, per Wishbone rules. Changing the address mid-cycle re-routes immediately.
- Burst cycles (cti 001/010) pass through unchanged. Slave selection is re-evaluated every beat.

## Configuration
- MSI_WB_MUX_UNMAPPED_ERR_EN defined: unmapped accesses produce the registered err pulse described above.
- Not defined: err_q is absent and wbm_err_o = wbs_err_i[selected] only. An unmapped access receives no termination, and the master must time out.

## Test plan
- NUM_SLAVES=4, MATCH_ADDR={0x300,0x200,0x100,0x000}, MATCH_MASK=0xffffff00 each:
  - Write 0xDEADBEEF to 0x104 → only wbs_cyc_o[1] high. Slave 1 acks, then wbm_ack_o=1 in the same cycle.
  - Read 0x2FC, with slave 2 returning 0x12345678 and ack → wbm_dat_o=0x12345678 with wbm_ack_o in the same cycle. wbs_cyc_o=4'b0100.
  - Access 0x400 with the macro defined → no wbs_cyc_o asserted. wbm_err_o=1 for exactly one cycle, one clock after cyc&stb.
  - Overlap test: MATCH_ADDR[0]=MATCH_ADDR[1]=0x000, access 0x010 → slave 0 selected.
  - Drive wb_rst_i low during an unmapped access → wbm_err_o drops immediately.
  - Randomized traffic, 1000 accesses over 0x000–0x3FF → per-slave write counts sum to total writes. Read-back data matches written data.
